// File: rtl/power_sequencer.sv
// Blade power sequencer: accepts setting requests, ramps the datapath's
// powerSetting one step at a time, recharges while off, and locks out
// into charge-only mode when the reservoir runs dry.
//
// state    | meaning
// ---------+--------------------------------------------------------
// OFF      | blade dark, charging until the reservoir is full
// IGNITE   | ramping the setting up toward target
// ON       | holding target, accepting new requests
// RETRACT  | ramping the setting down toward target (0 = turning off)
// LOCKOUT  | reservoir emptied, charge-only until RESUME_LVL reached
module power_sequencer #(
  parameter int unsigned MAX_LVL    = 179,
  parameter int unsigned LOW_LVL    = 20,
  parameter int unsigned RESUME_LVL = 40,
  parameter int unsigned RAMP_CYC   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_setting,
  output logic       req_ready,
  input  logic [7:0] level,
  output logic [1:0] power_setting,
  output logic       power_mode,
  output logic       active,
  output logic       low_warn,
  output logic       lockout,
  output logic       req_rej,
  output logic [2:0] state
);

  localparam int CW = $clog2(RAMP_CYC) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RAMP_CYC - 1);
  localparam logic [7:0] MAX_L    = 8'(MAX_LVL);
  localparam logic [7:0] LOW_L    = 8'(LOW_LVL);
  localparam logic [7:0] RESUME_L = 8'(RESUME_LVL);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_IGNITE  = 3'd1,
    S_ON      = 3'd2,
    S_RETRACT = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t        curState, nState;
  logic [1:0]    cur, nCur;
  logic [1:0]    target, nTarget;
  logic [CW-1:0] cnt, nCnt;
  logic          nRej;
  logic [1:0]    nSet;
  logic          nMode;
  logic          nDrainState;
  logic          reqAccept;

  assign state     = curState;
  assign req_ready = (curState == S_OFF) || ((curState == S_ON) && (level != 8'd0));
  assign reqAccept = req_valid && req_ready;

  // Next-state, ramp bookkeeping and the output values for the state being entered
  always_comb begin
    nState  = curState;
    nCur    = cur;
    nTarget = target;
    nCnt    = cnt;
    nRej    = 1'b0;
    case (curState)
      S_OFF: begin
        if (reqAccept && (req_setting != 2'd0)) begin
          if (level > LOW_L) begin
            nState  = S_IGNITE;
            nCur    = 2'd1;
            nTarget = req_setting;
            nCnt    = '0;
          end else begin
            nRej = 1'b1;
          end
        end
      end
      S_IGNITE: begin
        if (level == 8'd0) begin
          nState = S_LOCKOUT;
        end else if (cnt == CNT_LAST) begin
          nCnt = '0;
          if (cur == target) nState = S_ON;
          else               nCur   = cur + 2'd1;
        end else begin
          nCnt = cnt + CW'(1);
        end
      end
      S_ON: begin
        if (level == 8'd0) begin
          nState = S_LOCKOUT;
        end else if (reqAccept && (req_setting > target)) begin
          nState  = S_IGNITE;
          nCur    = target + 2'd1;
          nTarget = req_setting;
          nCnt    = '0;
        end else if (reqAccept && (req_setting < target)) begin
          nState  = S_RETRACT;
          nCur    = target - 2'd1;
          nTarget = req_setting;
          nCnt    = '0;
        end
      end
      S_RETRACT: begin
        if (level == 8'd0) begin
          nState = S_LOCKOUT;
        end else if (cnt == CNT_LAST) begin
          nCnt = '0;
          if (cur == target) nState = (target == 2'd0) ? S_OFF : S_ON;
          else               nCur   = cur - 2'd1;
        end else begin
          nCnt = cnt + CW'(1);
        end
      end
      S_LOCKOUT: begin
        if (level >= RESUME_L) nState = S_OFF;
      end
      default: nState = S_OFF;
    endcase

    // Emptying the reservoir discards any ramp in progress
    if (nState == S_LOCKOUT) begin
      nCur    = 2'd0;
      nTarget = 2'd0;
      nCnt    = '0;
    end

    nSet  = 2'd0;
    nMode = 1'b0;
    case (nState)
      S_OFF:              nSet = (level < MAX_L) ? 2'd1 : 2'd0;
      S_IGNITE, S_RETRACT: begin nSet = nCur;    nMode = 1'b1; end
      S_ON:               begin nSet = nTarget; nMode = 1'b1; end
      S_LOCKOUT:          nSet = 2'd1;
      default:            nSet = 2'd0;
    endcase
    nDrainState = (nState == S_IGNITE) || (nState == S_ON) || (nState == S_RETRACT);
  end

  // State and registered outputs; reset drops everything to a dark, idle OFF
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      curState      <= S_OFF;
      cur           <= 2'd0;
      target        <= 2'd0;
      cnt           <= '0;
      power_setting <= 2'd0;
      power_mode    <= 1'b0;
      active        <= 1'b0;
      low_warn      <= 1'b0;
      lockout       <= 1'b0;
      req_rej       <= 1'b0;
    end else begin
      curState      <= nState;
      cur           <= nCur;
      target        <= nTarget;
      cnt           <= nCnt;
      power_setting <= nSet;
      power_mode    <= nMode;
      active        <= (nSet != 2'd0) && nMode;
      low_warn      <= nDrainState && (level <= LOW_L);
      lockout       <= (nState == S_LOCKOUT);
      req_rej       <= nRej;
    end
  end

endmodule

// File: tb/tb_power_sequencer.sv
// Bench for power_sequencer: directed walk through the main scenarios with
// literal expectations, then randomized traffic against a schedule-based model.
module tb_power_sequencer;

  localparam int MAX_LVL = 179, LOW_LVL = 20, RESUME_LVL = 40, RAMP_CYC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_setting;
  logic       req_ready;
  logic [7:0] level;
  logic [1:0] power_setting;
  logic       power_mode, active, low_warn, lockout, req_rej;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  power_sequencer #(.MAX_LVL(MAX_LVL), .LOW_LVL(LOW_LVL), .RESUME_LVL(RESUME_LVL),
                    .RAMP_CYC(RAMP_CYC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_setting(req_setting),
    .req_ready(req_ready), .level(level), .power_setting(power_setting),
    .power_mode(power_mode), .active(active), .low_warn(low_warn),
    .lockout(lockout), .req_rej(req_rej), .state(state)
  );

  always #5 clk = ~clk;

  // Model: phase uses the documented state numbering; a ramp is a queue of
  // per-cycle settings, built when the ramp starts and drained one per edge.
  int mPhase, mTarget, mHeld;
  int eSet, eMode, eActive, eWarn, eLock, eRej;
  int sched[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPhase = 0; mTarget = 0; mHeld = 0;
    eSet = 0; eMode = 0; eActive = 0; eWarn = 0; eLock = 0; eRej = 0;
    sched.delete();
  endtask

  task automatic planRamp(input int a, input int b);
    int k;
    sched.delete();
    k = a;
    while (k != b) begin
      k += (b > a) ? 1 : -1;
      repeat (RAMP_CYC) sched.push_back(k);
    end
    mHeld = sched.pop_front();
  endtask

  task automatic goLock();
    mPhase = 4; mTarget = 0;
    sched.delete();
  endtask

  function automatic int expReady();
    return ((mPhase == 0) || (mPhase == 2 && level != 8'd0)) ? 1 : 0;
  endfunction

  task automatic modelStep(input int lv, input bit v, input int s);
    bit acc;
    acc = v && (expReady() != 0);
    eRej = 0;
    case (mPhase)
      0: if (acc && s > 0) begin
           if (lv > LOW_LVL) begin planRamp(0, s); mPhase = 1; mTarget = s; end
           else eRej = 1;
         end
      1, 3: if (lv == 0) goLock();
            else if (sched.size() > 0) mHeld = sched.pop_front();
            else mPhase = (mTarget == 0) ? 0 : 2;
      2: if (lv == 0) goLock();
         else if (acc && s != mTarget) begin
           mPhase = (s > mTarget) ? 1 : 3;
           planRamp(mTarget, s);
           mTarget = s;
         end
      4: if (lv >= RESUME_LVL) mPhase = 0;
      default: mPhase = 0;
    endcase
    case (mPhase)
      0:       begin eSet = (lv < MAX_LVL) ? 1 : 0; eMode = 0; end
      1, 3:    begin eSet = mHeld;   eMode = 1; end
      2:       begin eSet = mTarget; eMode = 1; end
      default: begin eSet = 1;       eMode = 0; end
    endcase
    eActive = (eSet != 0 && eMode == 1) ? 1 : 0;
    eWarn   = (mPhase >= 1 && mPhase <= 3 && lv <= LOW_LVL) ? 1 : 0;
    eLock   = (mPhase == 4) ? 1 : 0;
  endtask

  task automatic compareAll();
    chk("setting",  8'(power_setting), 8'(eSet));
    chk("mode",     8'(power_mode),    8'(eMode));
    chk("active",   8'(active),        8'(eActive));
    chk("low_warn", 8'(low_warn),      8'(eWarn));
    chk("lockout",  8'(lockout),       8'(eLock));
    chk("req_rej",  8'(req_rej),       8'(eRej));
    chk("state",    8'(state),         8'(mPhase));
  endtask

  // One clock: check ready for the inputs just driven, step the model at the
  // edge, compare registered outputs shortly after, return at the negedge.
  task automatic cyc();
    #1 chk("req_ready", 8'(req_ready), 8'(expReady()));
    @(posedge clk);
    if (rst) modelStep(int'(level), req_valid, int'(req_setting));
    else     modelReset();
    #1 compareAll();
    @(negedge clk);
  endtask

  task automatic request(input int s);
    req_valid = 1'b1; req_setting = 2'(s);
    cyc();
    req_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_setting = 2'd0; level = 8'd100;
    modelReset();
    repeat (2) @(negedge clk);
    chk("rst_setting", 8'(power_setting), 8'd0);
    chk("rst_mode",    8'(power_mode),    8'd0);
    chk("rst_state",   8'(state),         8'd0);
    chk("rst_lockout", 8'(lockout),       8'd0);

    rst = 1'b1;
    cyc();
    chk("boot_setting", 8'(power_setting), 8'd1);
    chk("boot_mode",    8'(power_mode),    8'd0);
    level = 8'd179;
    cyc();
    chk("full_setting", 8'(power_setting), 8'd0);

    // Ignite to 3
    level = 8'd100; req_valid = 1'b1; req_setting = 2'd3;
    #1 chk("off_ready", 8'(req_ready), 8'd1);
    cyc();
    req_valid = 1'b0;
    chk("ign_state", 8'(state), 8'd1);
    chk("ign_setting0", 8'(power_setting), 8'd1);
    for (int i = 1; i < 12; i++) begin
      cyc();
      chk("ign_setting", 8'(power_setting), 8'(i / 4 + 1));
    end
    cyc();
    chk("on_state",   8'(state),         8'd2);
    chk("on_active",  8'(active),        8'd1);
    chk("on_mode",    8'(power_mode),    8'd1);
    chk("on_setting", 8'(power_setting), 8'd3);
    #1 chk("on_ready", 8'(req_ready), 8'd1);

    // Down to 1, then off
    request(1);
    chk("ret_state", 8'(state), 8'd3);
    chk("ret_setting0", 8'(power_setting), 8'd2);
    for (int i = 1; i < 8; i++) begin
      cyc();
      chk("ret_setting", 8'(power_setting), (i < 4) ? 8'd2 : 8'd1);
    end
    cyc();
    chk("on1_state", 8'(state), 8'd2);
    chk("on1_setting", 8'(power_setting), 8'd1);
    request(0);
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk("off_ramp_setting", 8'(power_setting), 8'd0);
    end
    cyc();
    chk("off_state",   8'(state),         8'd0);
    chk("off_setting", 8'(power_setting), 8'd1);
    chk("off_mode",    8'(power_mode),    8'd0);

    // Lockout from ON at 2
    request(2);
    repeat (8) cyc();
    chk("on2_state", 8'(state), 8'd2);
    level = 8'd0;
    cyc();
    chk("lk_state",   8'(state),         8'd4);
    chk("lk_flag",    8'(lockout),       8'd1);
    chk("lk_setting", 8'(power_setting), 8'd1);
    chk("lk_mode",    8'(power_mode),    8'd0);
    #1 chk("lk_ready", 8'(req_ready), 8'd0);
    level = 8'd39;
    cyc();
    chk("lk_hold", 8'(state), 8'd4);
    level = 8'd40;
    cyc();
    chk("lk_exit", 8'(state), 8'd0);

    // Refusal at the low threshold, acceptance just above it
    level = 8'd20;
    request(2);
    chk("rej_pulse", 8'(req_rej), 8'd1);
    chk("rej_state", 8'(state),   8'd0);
    cyc();
    chk("rej_clear", 8'(req_rej), 8'd0);
    level = 8'd21;
    request(2);
    chk("ign21_state", 8'(state), 8'd1);
    repeat (8) cyc();
    chk("on21_state", 8'(state), 8'd2);
    level = 8'd15;
    cyc();
    chk("low_warn_on", 8'(low_warn), 8'd1);

    // Back to OFF, then reset mid-ignite at setting 2
    request(0);
    repeat (8) cyc();
    chk("off2_state", 8'(state), 8'd0);
    level = 8'd100;
    request(3);
    repeat (4) cyc();
    chk("mid_setting", 8'(power_setting), 8'd2);
    #2 rst = 1'b0;
    #1;
    chk("async_setting", 8'(power_setting), 8'd0);
    chk("async_state",   8'(state),         8'd0);
    chk("async_mode",    8'(power_mode),    8'd0);
    chk("async_active",  8'(active),        8'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("post_rst_state",   8'(state),         8'd0);
    chk("post_rst_setting", 8'(power_setting), 8'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2)       level = 8'd0;
      else if (r < 12) level = 8'($urandom_range(15, 45));
      else if (r < 18) level = 8'($urandom_range(170, 255));
      else if (r < 24) level = 8'($urandom_range(1, 255));
      req_valid   = ($urandom_range(0, 3) == 0);
      req_setting = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        modelReset();
        #1 compareAll();
        @(negedge clk);
        rst = 1'b1;
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
